result_drain: RTL and testbench
===============================

RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 Parameters SHALL be: WL, 32, result word width; DEPTH, 16, FIFO entries (power of 2, > PIPDEP); PIPDEP, 5, result pipeline depth of upstream PE; TILE, 4, results per output tile (>= 1).
REQ-002 clk  input  1  single clock, all logic on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 resultvalid  input  1  upstream PE result strobe.
REQ-005 resultvalue  input  WL  upstream PE result word.
REQ-006 arrayena  output  1  enable to upstream PE array (its ena input).
REQ-007 outvalid  output  1  outdata holds a valid word.
REQ-008 outready  input  1  downstream accepts the word.
REQ-009 outdata  output  WL  head-of-FIFO result.
REQ-010 outlast  output  1  current word is the last of a TILE-word tile.
REQ-011 overflow  output  1  sticky: a result was dropped.
REQ-012 level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-013 Push SHALL occur on a cycle with resultvalid=1 and (level<DEPTH or pop on the same cycle); resultvalue is written at the write pointer.
REQ-014 Pop SHALL occur on a cycle with outvalid=1 and outready=1; read pointer advances by 1.
REQ-015 Pointers SHALL wrap modulo DEPTH; level SHALL update +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-016 outvalid SHALL equal (level!=0); outdata SHALL equal the entry at the read pointer; a pushed word is first visible on outdata the cycle after the push (no same-cycle bypass).
REQ-017 When full (level=DEPTH) with simultaneous pop, a push SHALL be accepted; without pop, the word SHALL be discarded and overflow set to 1 from the next cycle.
REQ-018 overflow SHALL remain 1 until rst.
REQ-019 arrayena SHALL be registered and equal 1 iff (DEPTH - level) > PIPDEP after the update of that edge, so in-flight PE results (up to PIPDEP, since PE valid pipeline ignores ena) fit without overflow.
REQ-020 A tile counter SHALL count pops modulo TILE; outlast SHALL be 1 iff outvalid=1 and counter=TILE-1; counter wraps to 0 on the pop with outlast=1.
REQ-021 FIFO ordering SHALL be strict first-in first-out; no word is reordered or duplicated.
REQ-022 Storage contents SHALL NOT require reset; only control state is reset.

Reset
REQ-023 While rst=1: pointers 0, level 0, outvalid 0, outlast 0, overflow 0, tile counter 0, arrayena 0; outdata value don't-care.
REQ-024 On the first rising edge after rst deasserts, arrayena SHALL become 1.
REQ-025 Reset asserted mid-operation SHALL discard all buffered words and the partial tile; no pop or push occurs in the reset cycle.

Verification
REQ-026 Reset: rst pulse -> outvalid=0, level=0, arrayena=0 during rst, arrayena=1 one edge after release.
REQ-027 Stream: outready=1, push 10,20,30,40 on consecutive cycles -> outdata 10,20,30,40 each one cycle after push, outlast=1 only with 40, level never >1.
REQ-028 Backpressure: outready=0, push 11 words -> arrayena falls on edge where level becomes 11 (free 5 = PIPDEP); level=16 after 5 more pushes, overflow=0.
REQ-029 Overflow: at level=16, outready=0, push 0xDEAD -> level stays 16, overflow=1 next cycle, 0xDEAD never appears on outdata.
REQ-030 Full with pop: level=16, outready=1 and push 0xBEEF same cycle -> level stays 16, overflow=0, 0xBEEF emerges 16 pops later.
REQ-031 Reset mid-tile: pop 2 words of a tile, assert rst with 5 words buffered -> level=0, outvalid=0; next 4 pushed words form a new tile with outlast on the 4th.

Source files
------------

// File: rtl/result_drain_if.sv
// Handshake bundle between the PE result stream, the drain FIFO and the downstream consumer.
// The drain is the slave. The PE and consumer side is the master.
interface result_drain_if #(
  parameter int unsigned WL    = 32,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic          resultvalid;
  logic [WL-1:0] resultvalue;
  logic          arrayena;
  logic          outvalid;
  logic          outready;
  logic [WL-1:0] outdata;
  logic          outlast;
  logic          overflow;
  logic [LW-1:0] level;

  modport slave (
    input  resultvalid, resultvalue, outready,
    output arrayena, outvalid, outdata, outlast, overflow, level
  );

  modport master (
    output resultvalid, resultvalue, outready,
    input  arrayena, outvalid, outdata, outlast, overflow, level
  );
endinterface

// File: rtl/result_drain.sv
// Drains upstream PE results through a FIFO into tiled output words.
// It throttles the PE array early enough that in-flight results still fit.
module result_drain #(
  parameter int unsigned WL     = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned PIPDEP = 5,
  parameter int unsigned TILE   = 4
) (
  input  logic          clk,
  input  logic          rst,
  result_drain_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = (TILE > 1) ? $clog2(TILE) : 1;

  logic [WL-1:0] mem [DEPTH];
  logic [AW-1:0] wrptr, rdptr;
  logic [LW-1:0] level_q, level_d;
  logic [CW-1:0] tilecnt_q, tilecnt_d;
  logic          outvalid_q, outlast_q, overflow_q, arrayena_q;
  logic          full_c, pop_c, push_c, drop_c, ena_c;

  // Handshake qualification and next-state of the occupancy and tile counters
  always_comb begin
    full_c    = (level_q == LW'(DEPTH));
    pop_c     = outvalid_q && bus.outready;
    push_c    = bus.resultvalid && (!full_c || pop_c);
    drop_c    = bus.resultvalid && !push_c;
    level_d   = level_q;
    tilecnt_d = tilecnt_q;
    if (push_c && !pop_c) begin
      level_d = level_q + LW'(1);
    end else if (pop_c && !push_c) begin
      level_d = level_q - LW'(1);
    end
    if (pop_c) begin
      tilecnt_d = (tilecnt_q == CW'(TILE - 1)) ? CW'(0) : tilecnt_q + CW'(1);
    end
    ena_c = (DEPTH - 32'(level_d)) > PIPDEP;
  end

  // Storage is data-only. Stale entries are never visible because the pointers are reset.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wrptr] <= bus.resultvalue;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrptr      <= '0;
      rdptr      <= '0;
      level_q    <= '0;
      tilecnt_q  <= '0;
      outvalid_q <= 1'b0;
      outlast_q  <= 1'b0;
      overflow_q <= 1'b0;
      arrayena_q <= 1'b0;
    end else begin
      if (push_c) begin
        wrptr <= wrptr + AW'(1);
      end
      if (pop_c) begin
        rdptr <= rdptr + AW'(1);
      end
      level_q    <= level_d;
      tilecnt_q  <= tilecnt_d;
      outvalid_q <= (level_d != '0);
      outlast_q  <= (level_d != '0) && (tilecnt_d == CW'(TILE - 1));
      overflow_q <= overflow_q || drop_c;
      arrayena_q <= ena_c;
    end
  end

  assign bus.outdata  = mem[rdptr];
  assign bus.outvalid = outvalid_q;
  assign bus.outlast  = outlast_q;
  assign bus.overflow = overflow_q;
  assign bus.arrayena = arrayena_q;
  assign bus.level    = level_q;
endmodule

// File: tb/tb_result_drain.sv
// Randomized and directed bench for result_drain.
// Every output is checked against a queue-based reference model after each clock edge.
module tb_result_drain;
  localparam int unsigned WL     = 32;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned PIPDEP = 5;
  localparam int unsigned TILE   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  result_drain_if #(.WL(WL), .DEPTH(DEPTH)) bus ();

  result_drain #(.WL(WL), .DEPTH(DEPTH), .PIPDEP(PIPDEP), .TILE(TILE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  // Reference model: contents in arrival order plus sticky and tile bookkeeping
  int unsigned q[$];
  bit          m_ovf;
  int          m_tcnt;
  bit          m_ena;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    q.delete();
    m_ovf  = 1'b0;
    m_tcnt = 0;
    m_ena  = 1'b0;
  endfunction

  function automatic void model_edge(input bit v, input int unsigned d, input bit r);
    bit pop, push;
    pop  = (q.size() != 0) && r;
    push = v && ((q.size() < DEPTH) || pop);
    if (pop) begin
      void'(q.pop_front());
      m_tcnt = (m_tcnt == TILE - 1) ? 0 : m_tcnt + 1;
    end
    if (push) q.push_back(d);
    if (v && !push) m_ovf = 1'b1;
    m_ena = (int'(DEPTH) - int'(q.size())) > int'(PIPDEP);
  endfunction

  task automatic compare_all();
    check("outvalid", 32'(bus.outvalid), 32'(q.size() != 0));
    check("level",    32'(bus.level),    q.size());
    if (q.size() != 0) check("outdata", bus.outdata, q[0]);
    check("outlast",  32'(bus.outlast),  32'((q.size() != 0) && (m_tcnt == TILE - 1)));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    check("arrayena", 32'(bus.arrayena), 32'(m_ena));
  endtask

  // One clock: drive away from the edge, advance the model at the edge, sample 1 time unit later
  task automatic step(input bit v, input int unsigned d, input bit r);
    bus.resultvalid = v;
    bus.resultvalue = d;
    bus.outready    = r;
    @(posedge clk);
    model_edge(v, d, r);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    bus.resultvalid = 1'b0;
    bus.outready    = 1'b0;
    rst = 1'b1;
    #1;
    model_clear();
    check("rst_outvalid", 32'(bus.outvalid), 32'd0);
    check("rst_level",    32'(bus.level),    32'd0);
    check("rst_arrayena", 32'(bus.arrayena), 32'd0);
    check("rst_outlast",  32'(bus.outlast),  32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_arrayena", 32'(bus.arrayena), 32'd0);
    rst = 1'b0;
  endtask

  int unsigned vals [4] = '{32'd10, 32'd20, 32'd30, 32'd40};

  initial begin
    bus.resultvalid = 1'b0;
    bus.resultvalue = '0;
    bus.outready    = 1'b0;

    // Reset and release
    do_reset();
    step(1'b0, 0, 1'b0);
    check("release_arrayena", 32'(bus.arrayena), 32'd1);

    // Streaming with the consumer always ready
    for (int i = 0; i < 4; i++) begin
      step(1'b1, vals[i], 1'b1);
      check("stream_data",  bus.outdata, vals[i]);
      check("stream_last",  32'(bus.outlast), 32'(i == 3));
      check("stream_level", 32'(bus.level), 32'd1);
    end
    step(1'b0, 0, 1'b1);
    check("stream_drained", 32'(bus.level), 32'd0);

    // Backpressure: arrayena drops once free space reaches PIPDEP
    do_reset();
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 32'h100 + 32'(i), 1'b0);
      check("bp_arrayena", 32'(bus.arrayena), 32'(i < 10));
    end
    for (int i = 11; i < 16; i++) step(1'b1, 32'h100 + 32'(i), 1'b0);
    check("bp_full_level", 32'(bus.level), 32'd16);
    check("bp_no_overflow", 32'(bus.overflow), 32'd0);

    // A push into a full FIFO with no pop is dropped
    step(1'b1, 32'hDEAD, 1'b0);
    check("ovf_level", 32'(bus.level), 32'd16);
    check("ovf_flag",  32'(bus.overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 0, 1'b1);
      if (bus.outvalid) check("ovf_no_dead", 32'(bus.outdata == 32'hDEAD), 32'd0);
    end
    check("ovf_sticky", 32'(bus.overflow), 32'd1);

    // A push into a full FIFO with a simultaneous pop is accepted
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 32'h200 + 32'(i), 1'b0);
    step(1'b1, 32'hBEEF, 1'b1);
    check("fullpop_level", 32'(bus.level), 32'd16);
    check("fullpop_ovf",   32'(bus.overflow), 32'd0);
    for (int i = 0; i < 15; i++) step(1'b0, 0, 1'b1);
    check("fullpop_beef", bus.outdata, 32'hBEEF);
    step(1'b0, 0, 1'b1);

    // Reset in the middle of a tile discards the buffered words and the tile count
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 32'h300 + 32'(i), 1'b0);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b1);
    bus.outready = 1'b0;
    check("midtile_buffered", 32'(bus.level), 32'd5);
    do_reset();
    check("midtile_level",    32'(bus.level), 32'd0);
    check("midtile_outvalid", 32'(bus.outvalid), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h400 + 32'(i), 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("midtile_last", 32'(bus.outlast), 32'(i == 3));
      step(1'b0, 0, 1'b1);
    end

    // Random traffic with phases of different consumer duty cycles and occasional resets
    do_reset();
    for (int n = 0; n < 2400; n++) begin
      int unsigned phase;
      bit v, r;
      phase = (n / 200) % 4;
      v = ($urandom_range(99) < 70);
      case (phase)
        0:       r = ($urandom_range(99) < 90);
        1:       r = ($urandom_range(99) < 20);
        2:       r = ($urandom_range(99) < 55);
        default: r = ($urandom_range(99) < 5);
      endcase
      if ($urandom_range(999) < 3) begin
        do_reset();
      end else begin
        step(v, $urandom, r);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
